// File: rtl/fpu_decode_issue_if.sv
// Handshake bundle between the core, the decode/issue stage and the FPU
// execute unit.
//   core -> stage : insn_valid, insn, rs1/rs2/rs3_data, frm, flush
//   stage -> core : insn_ready, illegal_valid, illegal_insn
//   stage -> exec : op_valid, op_code, op_rm, op_a, op_b, op_c, op_rd
//   exec -> stage : op_ready
// The slave modport is the decode/issue stage; master is its environment.
interface fpu_decode_issue_if #(
   parameter int OPC_W = 4
) ();
   logic             flush;
   logic             insn_valid;
   logic             insn_ready;
   logic [31:0]      insn;
   logic [31:0]      rs1_data;
   logic [31:0]      rs2_data;
   logic [31:0]      rs3_data;
   logic [2:0]       frm;
   logic             op_valid;
   logic             op_ready;
   logic [OPC_W-1:0] op_code;
   logic [2:0]       op_rm;
   logic [15:0]      op_a;
   logic [15:0]      op_b;
   logic [15:0]      op_c;
   logic [4:0]       op_rd;
   logic             illegal_valid;
   logic [31:0]      illegal_insn;

   modport slave (
      input  flush, insn_valid, insn, rs1_data, rs2_data, rs3_data, frm, op_ready,
      output insn_ready, op_valid, op_code, op_rm, op_a, op_b, op_c, op_rd,
             illegal_valid, illegal_insn
   );

   modport master (
      output flush, insn_valid, insn, rs1_data, rs2_data, rs3_data, frm, op_ready,
      input  insn_ready, op_valid, op_code, op_rm, op_a, op_b, op_c, op_rd,
             illegal_valid, illegal_insn
   );
endinterface

// File: rtl/fpu_decode_issue.sv
// Decode and issue stage for the half-precision (Zhinx) FPU.
// Accepts RV32 instruction words plus integer operands, decodes them into an
// FPU op code with a resolved rounding mode, and buffers legal ops in a small
// circular issue queue. Illegal words consume the handshake and raise a
// one-cycle illegal_valid pulse with the word captured in illegal_insn.
// Ports:
//   CLK  - clock, rising edge
//   rst  - synchronous active-high reset (priority over flush)
//   bus  - fpu_decode_issue_if.slave (core and execute handshakes, flush)
module fpu_decode_issue #(
   parameter int DEPTH = 2,
   parameter int OPC_W = 4
) (
   input logic               CLK,
   input logic               rst,
   fpu_decode_issue_if.slave bus
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   typedef enum logic [OPC_W-1:0] {
      OP_ADD = 0, OP_SUB = 1, OP_MUL = 2, OP_DIV = 3, OP_MIN = 4, OP_MAX = 5,
      OP_SQRT = 6, OP_SGNJ = 7, OP_COMP = 8, OP_CLASS = 9, OP_MADD = 10,
      OP_MSUB = 11, OP_NMADD = 12, OP_NMSUB = 13
   } fpu_op_e;

   typedef struct packed {
      logic [OPC_W-1:0] code;
      logic [2:0]       rm;
      logic [15:0]      a;
      logic [15:0]      b;
      logic [15:0]      c;
      logic [4:0]       rd;
   } entry_t;

   entry_t           mem_q [DEPTH];
   entry_t           mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             insn_ready_q, insn_ready_d;
   logic             illegal_valid_q, illegal_valid_d;
   logic [31:0]      illegal_insn_q, illegal_insn_d;

   logic [4:0] funct5, rs2, rd;
   logic [1:0] fmt;
   logic [2:0] rm;
   logic [6:0] opcode;
   logic       fmt_ok, dec_legal, dec_arith, dec_fused;
   fpu_op_e    dec_op;
   logic [2:0] dec_rm;
   logic       push, pop, push_ok;

   // Upper operand halves are not used by half-precision ops.
   logic unused_bits;
   assign unused_bits = ^{bus.rs1_data[31:16], bus.rs2_data[31:16], bus.rs3_data[31:16]};

   assign funct5 = bus.insn[31:27];
   assign fmt    = bus.insn[26:25];
   assign rs2    = bus.insn[24:20];
   assign rm     = bus.insn[14:12];
   assign rd     = bus.insn[11:7];
   assign opcode = bus.insn[6:0];
   assign fmt_ok = (fmt == 2'b10);

   always_comb begin
      dec_legal = 1'b0;
      dec_arith = 1'b0;
      dec_fused = 1'b0;
      dec_op    = OP_ADD;
      dec_rm    = rm;
      case (opcode)
         7'b1010011: if (fmt_ok) begin
            case (funct5)
               5'b00000: begin dec_op = OP_ADD; dec_legal = 1'b1; dec_arith = 1'b1; end
               5'b00001: begin dec_op = OP_SUB; dec_legal = 1'b1; dec_arith = 1'b1; end
               5'b00010: begin dec_op = OP_MUL; dec_legal = 1'b1; dec_arith = 1'b1; end
               5'b00011: begin dec_op = OP_DIV; dec_legal = 1'b1; dec_arith = 1'b1; end
               5'b01011: begin dec_op = OP_SQRT; dec_legal = (rs2 == 5'd0); dec_arith = 1'b1; end
               5'b00101: begin
                  dec_op    = (rm == 3'b001) ? OP_MAX : OP_MIN;
                  dec_legal = (rm == 3'b000) || (rm == 3'b001);
               end
               5'b00100: begin dec_op = OP_SGNJ; dec_legal = (rm <= 3'b010); end
               5'b10100: begin dec_op = OP_COMP; dec_legal = (rm <= 3'b010); end
               5'b11100: begin dec_op = OP_CLASS; dec_legal = (rs2 == 5'd0) && (rm == 3'b001); end
               default: ;
            endcase
         end
         7'b1000011: begin dec_op = OP_MADD;  dec_legal = fmt_ok; dec_arith = 1'b1; dec_fused = 1'b1; end
         7'b1000111: begin dec_op = OP_MSUB;  dec_legal = fmt_ok; dec_arith = 1'b1; dec_fused = 1'b1; end
         7'b1001111: begin dec_op = OP_NMADD; dec_legal = fmt_ok; dec_arith = 1'b1; dec_fused = 1'b1; end
         7'b1001011: begin dec_op = OP_NMSUB; dec_legal = fmt_ok; dec_arith = 1'b1; dec_fused = 1'b1; end
         default: ;
      endcase
      // Arithmetic ops resolve DYN against frm; reserved modes are illegal.
      if (dec_arith) begin
         if (rm == 3'b101 || rm == 3'b110) begin
            dec_legal = 1'b0;
         end else if (rm == 3'b111) begin
            dec_rm = bus.frm;
            if (bus.frm >= 3'b101) dec_legal = 1'b0;
         end
      end
   end

   assign push    = bus.insn_valid && insn_ready_q;
   assign pop     = (count_q != '0) && bus.op_ready;
   assign push_ok = push && dec_legal;

   always_comb begin
      mem_d           = mem_q;
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      count_d         = count_q;
      illegal_valid_d = 1'b0;
      illegal_insn_d  = illegal_insn_q;
      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q].code = dec_op;
            mem_d[wr_ptr_q].rm   = dec_rm;
            mem_d[wr_ptr_q].a    = bus.rs1_data[15:0];
            mem_d[wr_ptr_q].b    = bus.rs2_data[15:0];
            mem_d[wr_ptr_q].c    = dec_fused ? bus.rs3_data[15:0] : 16'h0000;
            mem_d[wr_ptr_q].rd   = rd;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
         end else if (push) begin
            illegal_valid_d = 1'b1;
            illegal_insn_d  = bus.insn;
         end
         if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
      insn_ready_d = (count_d != CNT_W'(DEPTH));
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
         insn_ready_q    <= 1'b1;
         illegal_valid_q <= 1'b0;
         illegal_insn_q  <= '0;
      end else begin
         mem_q           <= mem_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         count_q         <= count_d;
         insn_ready_q    <= insn_ready_d;
         illegal_valid_q <= illegal_valid_d;
         illegal_insn_q  <= illegal_insn_d;
      end
   end

   assign bus.insn_ready    = insn_ready_q;
   assign bus.illegal_valid = illegal_valid_q;
   assign bus.illegal_insn  = illegal_insn_q;
   assign bus.op_valid      = (count_q != '0);
   assign bus.op_code       = mem_q[rd_ptr_q].code;
   assign bus.op_rm         = mem_q[rd_ptr_q].rm;
   assign bus.op_a          = mem_q[rd_ptr_q].a;
   assign bus.op_b          = mem_q[rd_ptr_q].b;
   assign bus.op_c          = mem_q[rd_ptr_q].c;
   assign bus.op_rd         = mem_q[rd_ptr_q].rd;
endmodule

// File: tb/tb_fpu_decode_issue.sv
// Directed self-checking bench for fpu_decode_issue.
module tb_fpu_decode_issue;
   logic CLK = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;

   fpu_decode_issue_if #(.OPC_W(4)) bus ();

   fpu_decode_issue #(.DEPTH(2), .OPC_W(4)) dut (
      .CLK (CLK),
      .rst (rst),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [31:0] add_rd(input logic [4:0] r);
      return 32'h04208053 | {20'd0, r, 7'd0};
   endfunction

   task automatic push_word(input logic [31:0] w, input logic [31:0] r1, input logic [31:0] r2,
                            input logic [31:0] r3, input logic [2:0] f);
      int unsigned n = 0;
      bus.insn = w; bus.rs1_data = r1; bus.rs2_data = r2; bus.rs3_data = r3; bus.frm = f;
      bus.insn_valid = 1'b1;
      while (bus.insn_ready !== 1'b1 && n < 10) begin tick(); n++; end
      if (n >= 10) begin
         checks++; failures++;
         $display("FAIL push_timeout insn_ready=%b required=1", bus.insn_ready);
      end
      tick();
      bus.insn_valid = 1'b0;
   endtask

   task automatic pop_one();
      bus.op_ready = 1'b1;
      tick();
      bus.op_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; tick(); tick();
      checks++; if (bus.op_valid !== 1'b0) begin failures++; $display("FAIL reset_op_valid got=%b exp=0", bus.op_valid); end
      checks++; if (bus.insn_ready !== 1'b1) begin failures++; $display("FAIL reset_insn_ready got=%b exp=1", bus.insn_ready); end
      checks++; if (bus.illegal_valid !== 1'b0) begin failures++; $display("FAIL reset_illegal_valid got=%b exp=0", bus.illegal_valid); end
      checks++; if (bus.illegal_insn !== 32'h0) begin failures++; $display("FAIL reset_illegal_insn got=%h exp=0", bus.illegal_insn); end
      checks++; if ({bus.op_code, bus.op_rm, bus.op_a, bus.op_b, bus.op_c, bus.op_rd} !== '0) begin
         failures++; $display("FAIL reset_op_data got=%h exp=0", {bus.op_code, bus.op_rm, bus.op_a, bus.op_b, bus.op_c, bus.op_rd});
      end
      rst = 1'b0; tick();
      checks++; if (bus.op_valid !== 1'b0) begin failures++; $display("FAIL reset_release_op_valid got=%b exp=0", bus.op_valid); end
   endtask

   task automatic test_add_basic();
      push_word(32'h042081D3, 32'h3C00, 32'h4000, 32'h0, 3'b000);
      checks++; if (bus.op_valid !== 1'b1) begin failures++; $display("FAIL add_op_valid got=%b exp=1", bus.op_valid); end
      checks++; if (bus.op_code !== 4'd0) begin failures++; $display("FAIL add_op_code got=%0d exp=0", bus.op_code); end
      checks++; if (bus.op_rm !== 3'b000) begin failures++; $display("FAIL add_op_rm got=%b exp=000", bus.op_rm); end
      checks++; if (bus.op_a !== 16'h3C00) begin failures++; $display("FAIL add_op_a got=%h exp=3c00", bus.op_a); end
      checks++; if (bus.op_b !== 16'h4000) begin failures++; $display("FAIL add_op_b got=%h exp=4000", bus.op_b); end
      checks++; if (bus.op_c !== 16'h0000) begin failures++; $display("FAIL add_op_c got=%h exp=0000", bus.op_c); end
      checks++; if (bus.op_rd !== 5'd3) begin failures++; $display("FAIL add_op_rd got=%0d exp=3", bus.op_rd); end
      pop_one();
      checks++; if (bus.op_valid !== 1'b0) begin failures++; $display("FAIL add_drain got=%b exp=0", bus.op_valid); end
   endtask

   task automatic test_dyn_rm();
      push_word(32'h0420F1D3, 32'h1, 32'h2, 32'h0, 3'b010);
      checks++; if (bus.op_valid !== 1'b1) begin failures++; $display("FAIL dyn_op_valid got=%b exp=1", bus.op_valid); end
      checks++; if (bus.op_rm !== 3'b010) begin failures++; $display("FAIL dyn_op_rm got=%b exp=010", bus.op_rm); end
      bus.frm = 3'b111; bus.rs1_data = 32'hFFFF; tick();
      checks++; if (bus.op_rm !== 3'b010 || bus.op_a !== 16'h0001) begin
         failures++; $display("FAIL dyn_sampled got rm=%b a=%h exp rm=010 a=0001", bus.op_rm, bus.op_a);
      end
      pop_one();
      push_word(32'h0420F1D3, 32'h1, 32'h2, 32'h0, 3'b101);
      checks++; if (bus.illegal_valid !== 1'b1) begin failures++; $display("FAIL dyn_bad_frm_pulse got=%b exp=1", bus.illegal_valid); end
      checks++; if (bus.illegal_insn !== 32'h0420F1D3) begin failures++; $display("FAIL dyn_bad_frm_insn got=%h exp=0420f1d3", bus.illegal_insn); end
      checks++; if (bus.op_valid !== 1'b0) begin failures++; $display("FAIL dyn_bad_frm_op_valid got=%b exp=0", bus.op_valid); end
      tick();
      checks++; if (bus.illegal_valid !== 1'b0) begin failures++; $display("FAIL dyn_pulse_width got=%b exp=0", bus.illegal_valid); end
      checks++; if (bus.illegal_insn !== 32'h0420F1D3) begin failures++; $display("FAIL dyn_insn_hold got=%h exp=0420f1d3", bus.illegal_insn); end
   endtask

   task automatic test_illegal();
      logic [31:0] bad [10] = '{32'h002081D3, 32'h00000013, 32'h5C1081D3, 32'h2C20A1D3, 32'h0C20D1C3,
                               32'hE40081D3, 32'hFC2081D3, 32'h2420B1D3, 32'h082081C3, 32'h0420E1D3};
      push_word(32'h042081D3, 32'h3C00, 32'h4000, 32'h0, 3'b000);
      push_word(32'h002081D3, 32'h0, 32'h0, 32'h0, 3'b000);
      checks++; if (bus.illegal_valid !== 1'b1) begin failures++; $display("FAIL ill_fmt_pulse got=%b exp=1", bus.illegal_valid); end
      checks++; if (bus.insn_ready !== 1'b1 || bus.op_valid !== 1'b1) begin
         failures++; $display("FAIL ill_count_unchanged got ready=%b valid=%b exp 1 1", bus.insn_ready, bus.op_valid);
      end
      checks++; if (bus.op_rd !== 5'd3 || bus.op_a !== 16'h3C00) begin
         failures++; $display("FAIL ill_head_kept got rd=%0d a=%h exp rd=3 a=3c00", bus.op_rd, bus.op_a);
      end
      tick();
      checks++; if (bus.illegal_valid !== 1'b0) begin failures++; $display("FAIL ill_fmt_one_cycle got=%b exp=0", bus.illegal_valid); end
      pop_one();
      checks++; if (bus.op_valid !== 1'b0) begin failures++; $display("FAIL ill_single_entry got=%b exp=0", bus.op_valid); end
      push_word(32'hE40091D3, 32'h0, 32'h0, 32'h0, 3'b000);
      checks++; if (bus.op_code !== 4'd9 || bus.op_rm !== 3'b001) begin
         failures++; $display("FAIL class_decode got code=%0d rm=%b exp code=9 rm=001", bus.op_code, bus.op_rm);
      end
      pop_one();
      for (int unsigned i = 0; i < 10; i++) begin
         push_word(bad[i], 32'h0, 32'h0, 32'h0, 3'b100);
         checks++; if (bus.illegal_valid !== 1'b1 || bus.illegal_insn !== bad[i] || bus.op_valid !== 1'b0) begin
            failures++; $display("FAIL ill_table[%0d] got pulse=%b insn=%h valid=%b exp pulse=1 insn=%h valid=0",
                                 i, bus.illegal_valid, bus.illegal_insn, bus.op_valid, bad[i]);
         end
      end
      tick();
   endtask

   task automatic test_decode_table();
      logic [31:0] w  [14] = '{32'h042081D3, 32'h0C2081D3, 32'h142081D3, 32'h1C2081D3, 32'h1420F1D3,
                              32'h0C2081C3, 32'h0C2081C7, 32'h0C2081CF, 32'h0C2081CB, 32'h5C0081D3,
                              32'h2C2081D3, 32'h2C2091D3, 32'h2420A1D3, 32'hA420A1D3};
      logic [3:0]  oc [14] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd2, 4'd10, 4'd11, 4'd12, 4'd13, 4'd6,
                              4'd4, 4'd5, 4'd7, 4'd8};
      logic [2:0]  rr [14] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
                              3'd0, 3'd1, 3'd2, 3'd2};
      logic [15:0] cc [14] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hABCD, 16'hABCD, 16'hABCD, 16'hABCD,
                              16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
      for (int unsigned i = 0; i < 14; i++) begin
         push_word(w[i], 32'h11115555, 32'h2222AAAA, 32'h1234ABCD, 3'b100);
         checks++;
         if (bus.op_valid !== 1'b1 || bus.op_code !== oc[i] || bus.op_rm !== rr[i] || bus.op_a !== 16'h5555 ||
             bus.op_b !== 16'hAAAA || bus.op_c !== cc[i] || bus.op_rd !== 5'd3) begin
            failures++;
            $display("FAIL decode[%0d] got v=%b code=%0d rm=%b a=%h b=%h c=%h rd=%0d exp v=1 code=%0d rm=%b a=5555 b=aaaa c=%h rd=3",
                     i, bus.op_valid, bus.op_code, bus.op_rm, bus.op_a, bus.op_b, bus.op_c, bus.op_rd, oc[i], rr[i], cc[i]);
         end
         pop_one();
      end
   endtask

   task automatic test_backpressure();
      bus.op_ready = 1'b0; bus.frm = 3'b000;
      bus.insn = add_rd(5'd1); bus.rs1_data = 32'h0101; bus.insn_valid = 1'b1; tick();
      checks++; if (bus.insn_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_one got=%b exp=1", bus.insn_ready); end
      bus.insn = add_rd(5'd2); bus.rs1_data = 32'h0202; tick();
      checks++; if (bus.insn_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_full got=%b exp=0", bus.insn_ready); end
      bus.insn = add_rd(5'd3); bus.rs1_data = 32'h0303;
      for (int unsigned i = 0; i < 3; i++) begin
         tick();
         checks++; if (bus.insn_ready !== 1'b0 || bus.op_rd !== 5'd1 || bus.op_a !== 16'h0101) begin
            failures++; $display("FAIL bp_stable[%0d] got ready=%b rd=%0d a=%h exp ready=0 rd=1 a=0101", i, bus.insn_ready, bus.op_rd, bus.op_a);
         end
      end
      bus.insn_valid = 1'b0;
      pop_one();
      checks++; if (bus.op_rd !== 5'd2 || bus.op_a !== 16'h0202 || bus.insn_ready !== 1'b1) begin
         failures++; $display("FAIL bp_second got rd=%0d a=%h ready=%b exp rd=2 a=0202 ready=1", bus.op_rd, bus.op_a, bus.insn_ready);
      end
      pop_one();
      checks++; if (bus.op_valid !== 1'b0) begin failures++; $display("FAIL bp_third_held_off got=%b exp=0", bus.op_valid); end
   endtask

   task automatic test_back_to_back();
      push_word(add_rd(5'd0), 32'h0, 32'h0, 32'h0, 3'b000);
      for (int unsigned i = 0; i < 20; i++) begin
         bus.insn = add_rd(5'(i + 1)); bus.insn_valid = 1'b1; bus.op_ready = 1'b1;
         checks++; if (bus.op_valid !== 1'b1 || bus.op_rd !== 5'(i) || bus.insn_ready !== 1'b1) begin
            failures++; $display("FAIL b2b[%0d] got valid=%b rd=%0d ready=%b exp valid=1 rd=%0d ready=1",
                                 i, bus.op_valid, bus.op_rd, bus.insn_ready, i);
         end
         tick();
      end
      bus.insn_valid = 1'b0; bus.op_ready = 1'b0;
      checks++; if (bus.op_valid !== 1'b1 || bus.op_rd !== 5'd20 || bus.insn_ready !== 1'b1) begin
         failures++; $display("FAIL b2b_tail got valid=%b rd=%0d ready=%b exp valid=1 rd=20 ready=1", bus.op_valid, bus.op_rd, bus.insn_ready);
      end
      pop_one();
      checks++; if (bus.op_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", bus.op_valid); end
   endtask

   task automatic test_flush();
      push_word(add_rd(5'd1), 32'h0, 32'h0, 32'h0, 3'b000);
      push_word(add_rd(5'd2), 32'h0, 32'h0, 32'h0, 3'b000);
      bus.flush = 1'b1; bus.insn = add_rd(5'd9); bus.insn_valid = 1'b1; tick();
      bus.flush = 1'b0; bus.insn_valid = 1'b0;
      checks++; if (bus.op_valid !== 1'b0 || bus.insn_ready !== 1'b1) begin
         failures++; $display("FAIL flush_full got valid=%b ready=%b exp valid=0 ready=1", bus.op_valid, bus.insn_ready);
      end
      push_word(add_rd(5'd1), 32'h0, 32'h0, 32'h0, 3'b000);
      bus.flush = 1'b1; bus.insn = add_rd(5'd9); bus.insn_valid = 1'b1; tick();
      bus.flush = 1'b0; bus.insn_valid = 1'b0;
      checks++; if (bus.op_valid !== 1'b0 || bus.insn_ready !== 1'b1) begin
         failures++; $display("FAIL flush_push_dropped got valid=%b ready=%b exp valid=0 ready=1", bus.op_valid, bus.insn_ready);
      end
      bus.flush = 1'b1; bus.insn = 32'h00000013; bus.insn_valid = 1'b1; tick();
      bus.flush = 1'b0; bus.insn_valid = 1'b0;
      checks++; if (bus.illegal_valid !== 1'b0) begin failures++; $display("FAIL flush_illegal_suppressed got=%b exp=0", bus.illegal_valid); end
      push_word(add_rd(5'd4), 32'h0, 32'h0, 32'h0, 3'b000);
      checks++; if (bus.op_valid !== 1'b1 || bus.op_rd !== 5'd4) begin
         failures++; $display("FAIL flush_recover got valid=%b rd=%0d exp valid=1 rd=4", bus.op_valid, bus.op_rd);
      end
      pop_one();
   endtask

   task automatic test_reset_midstream();
      push_word(32'h00000013, 32'h0, 32'h0, 32'h0, 3'b000);
      push_word(add_rd(5'd5), 32'h7777, 32'h8888, 32'h0, 3'b000);
      push_word(add_rd(5'd6), 32'h7777, 32'h8888, 32'h0, 3'b000);
      rst = 1'b1; bus.flush = 1'b1; tick();
      rst = 1'b0; bus.flush = 1'b0;
      checks++; if (bus.op_valid !== 1'b0 || bus.insn_ready !== 1'b1 || bus.illegal_valid !== 1'b0 || bus.illegal_insn !== 32'h0) begin
         failures++; $display("FAIL rst_mid_ctrl got valid=%b ready=%b ill=%b insn=%h exp 0 1 0 00000000",
                              bus.op_valid, bus.insn_ready, bus.illegal_valid, bus.illegal_insn);
      end
      checks++; if ({bus.op_code, bus.op_rm, bus.op_a, bus.op_b, bus.op_c, bus.op_rd} !== '0) begin
         failures++; $display("FAIL rst_mid_data got=%h exp=0", {bus.op_code, bus.op_rm, bus.op_a, bus.op_b, bus.op_c, bus.op_rd});
      end
      tick();
      checks++; if (bus.op_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_dropped got=%b exp=0", bus.op_valid); end
   endtask

   initial begin
      rst = 1'b1;
      bus.flush = 1'b0; bus.insn_valid = 1'b0; bus.insn = '0;
      bus.rs1_data = '0; bus.rs2_data = '0; bus.rs3_data = '0; bus.frm = '0; bus.op_ready = 1'b0;
      test_reset();
      test_add_basic();
      test_dyn_rm();
      test_illegal();
      test_decode_table();
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fpu_decode_issue.md
Name: fpu_decode_issue

Overview:
Decode and issue stage in front of the half-precision FPU datapath. It accepts raw RV32 Zhinx instruction words and their integer-register operands from the core over a valid/ready handshake. Each word is decoded into an FPU operation code with a resolved rounding mode and 16-bit operands, then buffered in a 2-entry issue queue that drains to the execute unit over a second valid/ready handshake. Illegal encodings are not issued; they are reported to the core with a one-cycle exception pulse.

Parameters:
DEPTH, 2, issue-queue entries (the design is verified only at 2; any power of 2 ≥ 2 is legal)
OPC_W, 4, width of the operation code, which encodes the FPU operation enum values 0..13

Ports:
CLK  in  1  clock; all logic is on the rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  synchronous queue and pending-exception clear
insn_valid  in  1  core presents an instruction
insn_ready  out  1  decoder can accept; registered, equals (count != DEPTH)
insn  in  32  instruction word; fields are funct5/rs3[31:27], fmt[26:25], rs2[24:20], rs1[19:15], rm[14:12], rd[11:7], opcode[6:0]
rs1_data  in  32  integer register value; bits [15:0] are used
rs2_data  in  32  integer register value; bits [15:0] are used
rs3_data  in  32  integer register value; bits [15:0] are used
frm  in  3  dynamic rounding-mode CSR
op_valid  out  1  queue head is valid
op_ready  in  1  execute unit accepts the head
op_code  out  OPC_W  ADD=0, SUB=1, MUL=2, DIV=3, MIN=4, MAX=5, SQRT=6, SGNJ=7, COMP=8, CLASS=9, MADD=10, MSUB=11, NMADD=12, NMSUB=13
op_rm  out  3  resolved rounding mode for arithmetic ops; raw funct3 for SGNJ, COMP, MIN, MAX and CLASS
op_a, op_b, op_c  out  16  operands from rs1, rs2 and rs3 (op_c is 0 for non-fused ops)
op_rd  out  5  destination register
illegal_valid  out  1  one-cycle pulse for a rejected instruction
illegal_insn  out  32  captured illegal word; holds until the next illegal instruction or reset

Behaviour:
- A push occurs when insn_valid and insn_ready are both high. A pop occurs when op_valid and op_ready are both high.
- Latency: a word accepted at edge N has op_valid high, or illegal_valid pulsing, after edge N. Throughput is one instruction per cycle.
- frm and the operands are sampled at the push edge and do not affect the entry afterwards.
- Opcode 1010011 (OP-FP):
  - fmt must be 10 (HALF); any other fmt is illegal.
  - funct5 00000/00001/00010/00011 decode to ADD/SUB/MUL/DIV.
  - funct5 01011 decodes to SQRT and requires rs2=0.
  - funct5 00101 decodes to MIN when rm=000 and MAX when rm=001; any other rm is illegal.
  - funct5 00100 decodes to SGNJ with rm in {000,001,010}.
  - funct5 10100 decodes to COMP with rm in {000,001,010}.
  - funct5 11100 decodes to CLASS and requires rs2=0 and rm=001.
  - Any other funct5 is illegal.
- Opcodes 1000011/1000111/1001111/1001011 decode to MADD/MSUB/NMADD/NMSUB. fmt must be 10. rs3 is insn[31:27]; op_c = rs3_data[15:0].
- Any other opcode is illegal.
- Rounding mode for arithmetic ops (ADD, SUB, MUL, DIV, SQRT and the fused ops):
  - rm 101 or 110 is illegal.
  - rm 111 takes frm; if frm is 101, 110 or 111 the instruction is illegal.
  - Otherwise op_rm = rm.
- An illegal word is accepted (it consumes the handshake) but is not enqueued. At the next edge illegal_valid=1 and illegal_insn=insn.
- Queue:
  - Circular buffer with wrapping read and write pointers and a count of width log2(DEPTH)+1.
  - Outputs are driven directly from the head entry.
  - Push and pop in the same cycle leave count unchanged. No push is possible at full because insn_ready=0.
  - Pop on empty is impossible because op_valid=0.
  - An illegal push does not change count.
- flush: pointers and count go to 0 and illegal_valid goes to 0. A simultaneous push is discarded. insn_ready is 1 in the next cycle.
- Reset values: op_valid=0, insn_ready=1, illegal_valid=0, illegal_insn=0, count=0, pointers=0; op_* data outputs are 0.
- rst has priority over flush. Reset mid-stream drops all queued entries.
- op_* data outputs are stable while op_valid=1 and op_ready=0.

Test Plan:
1. Push 0x042081D3 with rs1_data=0x3C00 and rs2_data=0x4000 -> one cycle later: op_valid=1, op_code=0, op_rm=000, op_a=0x3C00, op_b=0x4000, op_rd=3.
2. Push 0x0420F1D3 (FADD.H, DYN) with frm=010 -> op_rm=010. Repeat with frm=101 -> illegal_valid pulses once, illegal_insn=0x0420F1D3, op_valid stays 0.
3. Push 0x002081D3 (fmt=single) -> illegal_valid=1 for exactly one cycle, count unchanged. Push 0xE40091D3 -> op_code=9, op_rm=001.
4. Hold op_ready=0 and push 3 valid words back-to-back -> insn_ready drops after the second accept. The third word is held off. op_* remain stable on the first word.
5. At count=1, raise op_ready and insn_valid together for 20 cycles with incrementing rd -> count stays 1. Issue order matches accept order with no loss or duplication across pointer wrap.
6. With 2 entries queued, assert flush while insn_valid=1 -> next cycle op_valid=0, insn_ready=1, and the flushed-cycle word is never issued. Repeat with rst -> all outputs return to their reset values.
